// File: rtl/fir_stream_pkg.sv
// Shared constants and types for the FIR result streamer.
// The FIFO entry keeps the saturation flag next to the sample it describes,
// so the flag always leaves the FIFO together with its sample.
package fir_stream_pkg;

  localparam int ECG_IN_W    = 59;
  localparam int FIR_LATENCY = 9;
  localparam int SAMPLE_W    = 16;

  // Signed clamp limits of the output sample, as raw bit patterns
  localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef struct packed {
    logic                sat;
    logic [SAMPLE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word fall-through FIFO.
// The pointers carry one extra wrap bit so that full and empty can be told
// apart when the address bits match. A push while full is accepted only
// when a pop happens in the same cycle, which frees the head slot that the
// write then reuses.
module sync_fifo_fwft #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Write and read pointers, cleared on reset to discard buffered entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_result_streamer.sv
// Output side of the ECG band-pass FIR.
// The filter runs free with no valid, so a delay line matched to its latency
// marks the cycles whose y_in belongs to a real input sample. Those results
// are rounded, saturated to a signed sample and queued for a valid/ready
// consumer, with overflow and saturation diagnostics alongside.
module fir_result_streamer
  import fir_stream_pkg::*;
#(
  parameter int IN_W    = ECG_IN_W,
  parameter int OUT_W   = SAMPLE_W,
  parameter int LATENCY = FIR_LATENCY,
  parameter int SHIFT   = 0,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     smp_valid_in,
  input  logic [IN_W-1:0]          y_in,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_W-1:0]         m_data,
  output logic                     m_sat,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf_sticky,
  input  logic                     ovf_clr,
  output logic [15:0]              sat_count
);

  // Clamp limits sign-extended to the width of the rounded intermediate
  localparam logic signed [IN_W:0] T_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] T_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [LATENCY-1:0]      vld_pipe;
  logic                    capture;
  logic signed [IN_W:0]    y_ext;
  logic signed [IN_W:0]    t;
  logic                    sat_hi;
  logic                    sat_lo;
  logic                    sat;
  logic [SAMPLE_W-1:0]     sat_val;
  fifo_entry_t             wr_entry;
  logic [$bits(fifo_entry_t)-1:0] rd_bits;
  fifo_entry_t             rd_entry;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    drop;

  // Valid delay line: the oldest bit lines up with the filter output of that sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | LATENCY'(smp_valid_in);
    end
  end

  assign capture = vld_pipe[LATENCY-1];

  // One extra bit of headroom so the rounding offset can never wrap
  assign y_ext = {y_in[IN_W-1], y_in};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [IN_W:0] HALF = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
      logic signed [IN_W:0] sum;
      assign sum = y_ext + HALF;
      assign t   = sum >>> SHIFT;
    end else begin : g_pass
      assign t = y_ext;
    end
  endgenerate

  assign sat_hi = (t > T_MAX);
  assign sat_lo = (t < T_MIN);
  assign sat    = sat_hi || sat_lo;

  // Clamp out-of-range results, otherwise keep the low sample bits
  always_comb begin
    sat_val = t[SAMPLE_W-1:0];
    if (sat_hi) begin
      sat_val = SAT_MAX;
    end else if (sat_lo) begin
      sat_val = SAT_MIN;
    end
  end

  assign wr_entry.sat  = sat;
  assign wr_entry.data = sat_val;

  // A capture into a full FIFO survives only if the head leaves in the same cycle
  assign pop  = !empty && m_ready;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  sync_fifo_fwft #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (rd_bits),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign rd_entry = fifo_entry_t'(rd_bits);
  assign m_valid  = !empty;
  assign m_data   = empty ? '0 : rd_entry.data;
  assign m_sat    = !empty && rd_entry.sat;

  // Overflow flag: a drop in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

  // Saturation counter, counting dropped captures too, and holding at its maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (capture && sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_result_streamer.sv
// Directed bench for fir_result_streamer: one instance with no shift and one
// with SHIFT=2 for the rounding cases. Outputs are checked 1ns after the
// rising edge; inputs are changed at the same point for the next cycle.
module tb_fir_result_streamer;

  localparam int IN_W  = 59;
  localparam int LVL_W = 5;

  logic clk = 1'b0;
  logic rst_n;

  logic              smp_valid_in;
  logic [IN_W-1:0]   y_in;
  logic              m_valid;
  logic              m_ready;
  logic [15:0]       m_data;
  logic              m_sat;
  logic [LVL_W-1:0]  fifo_level;
  logic              ovf_sticky;
  logic              ovf_clr;
  logic [15:0]       sat_count;

  logic              r_valid_in;
  logic [IN_W-1:0]   r_y;
  logic              r_m_valid;
  logic              r_ready;
  logic [15:0]       r_data;
  logic              r_sat;
  logic [LVL_W-1:0]  r_level;
  logic              r_ovf;
  logic [15:0]       r_sat_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_result_streamer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .smp_valid_in (smp_valid_in),
    .y_in         (y_in),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sat        (m_sat),
    .fifo_level   (fifo_level),
    .ovf_sticky   (ovf_sticky),
    .ovf_clr      (ovf_clr),
    .sat_count    (sat_count)
  );

  fir_result_streamer #(.SHIFT(2)) dut_r (
    .clk          (clk),
    .rst_n        (rst_n),
    .smp_valid_in (r_valid_in),
    .y_in         (r_y),
    .m_valid      (r_m_valid),
    .m_ready      (r_ready),
    .m_data       (r_data),
    .m_sat        (r_sat),
    .fifo_level   (r_level),
    .ovf_sticky   (r_ovf),
    .ovf_clr      (1'b0),
    .sat_count    (r_sat_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the main instance's capture inputs for the coming cycle
  task automatic applyStimulus(input logic vld, input longint v);
    smp_valid_in = vld;
    y_in         = v[IN_W-1:0];
  endtask

  // Hold a single sample in the delay line until its capture edge has passed
  task automatic captureOne(input longint v);
    applyStimulus(1'b1, v);
    step();
    smp_valid_in = 1'b0;
    repeat (9) step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    longint v;

    rst_n        = 1'b0;
    m_ready      = 1'b1;
    ovf_clr      = 1'b0;
    r_valid_in   = 1'b0;
    r_y          = '0;
    r_ready      = 1'b1;
    applyStimulus(1'b0, 0);

    // Reset state
    #1;
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_m_sat", 32'(m_sat), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_sticky), 32'd0);
    checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic latency: sample valid in cycle 10, result seen only in cycle 20
    for (int k = 0; k < 40; k++) begin
      checkOutput($sformatf("lat_m_valid_c%0d", k), 32'(m_valid), (k == 20) ? 32'd1 : 32'd0);
      if (k == 19) checkOutput("lat_empty_data", 32'(m_data), 32'd0);
      if (k == 20) begin
        checkOutput("lat_m_data", 32'(m_data), 32'h04D2);
        checkOutput("lat_m_sat", 32'(m_sat), 32'd0);
      end
      applyStimulus(k == 10, (k == 19) ? 1234 : 999);
      step();
    end

    // Saturation both ways, then an in-range extreme
    m_ready = 1'b0;
    captureOne(40000);
    captureOne(-40000);
    captureOne(32767);
    checkOutput("sat_level", 32'(fifo_level), 32'd3);
    checkOutput("sat_count2", 32'(sat_count), 32'd2);
    checkOutput("sat_hi_data", 32'(m_data), 32'h7FFF);
    checkOutput("sat_hi_flag", 32'(m_sat), 32'd1);
    m_ready = 1'b1;
    step();
    checkOutput("sat_lo_data", 32'(m_data), 32'h8000);
    checkOutput("sat_lo_flag", 32'(m_sat), 32'd1);
    step();
    checkOutput("max_data", 32'(m_data), 32'h7FFF);
    checkOutput("max_flag", 32'(m_sat), 32'd0);
    step();
    m_ready = 1'b0;
    checkOutput("sat_drained", 32'(m_valid), 32'd0);

    // Rounding with SHIFT=2: 7, 6, -7 -> 2, 2, -2
    r_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      r_valid_in = (i < 3);
      v = (i == 9) ? 64'sd7 : (i == 10) ? 64'sd6 : (i == 11) ? -64'sd7 : 64'sd0;
      r_y = v[IN_W-1:0];
      step();
    end
    checkOutput("rnd_level", 32'(r_level), 32'd3);
    checkOutput("rnd_pos7", 32'(r_data), 32'd2);
    r_ready = 1'b1;
    step();
    checkOutput("rnd_pos6", 32'(r_data), 32'd2);
    step();
    checkOutput("rnd_neg7", 32'(r_data), 32'h0000FFFE);
    checkOutput("rnd_sat", 32'(r_sat), 32'd0);
    step();
    checkOutput("rnd_drained", 32'(r_m_valid), 32'd0);

    // Backpressure: 18 back-to-back samples into a 16-deep FIFO
    for (int i = 0; i < 27; i++) begin
      applyStimulus(i < 18, (i >= 9) ? longint'(i - 8) : 0);
      step();
    end
    applyStimulus(1'b0, 0);
    checkOutput("ovf_level", 32'(fifo_level), 32'd16);
    checkOutput("ovf_set", 32'(ovf_sticky), 32'd1);
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checkOutput($sformatf("drain_%0d", i), 32'(m_data), 32'(i));
      step();
    end
    m_ready = 1'b0;
    checkOutput("drain_empty", 32'(m_valid), 32'd0);
    checkOutput("ovf_held", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", 32'(ovf_sticky), 32'd0);
    checkOutput("sat_count_kept", 32'(sat_count), 32'd2);

    // Full FIFO with a pop in the capture cycle of value 77
    for (int i = 0; i < 26; i++) begin
      applyStimulus(i < 17, (i < 9) ? 0 : (i - 9 < 16) ? longint'(100 + i - 9) : 77);
      if (i == 25) begin
        checkOutput("fp_full_level", 32'(fifo_level), 32'd16);
        m_ready = 1'b1;
      end
      step();
    end
    m_ready = 1'b0;
    applyStimulus(1'b0, 0);
    checkOutput("fp_level", 32'(fifo_level), 32'd16);
    checkOutput("fp_ovf", 32'(ovf_sticky), 32'd0);
    m_ready = 1'b1;
    for (int j = 1; j <= 15; j++) begin
      checkOutput($sformatf("fp_data_%0d", j), 32'(m_data), 32'(100 + j));
      step();
    end
    checkOutput("fp_last_77", 32'(m_data), 32'd77);
    step();
    m_ready = 1'b0;
    checkOutput("fp_empty", 32'(m_valid), 32'd0);

    // Reset mid-flight: 5 entries buffered, 3 still in the delay line
    for (int i = 0; i < 14; i++) begin
      applyStimulus(i < 8, (i >= 9) ? 500 : 0);
      step();
    end
    applyStimulus(1'b0, 555);
    checkOutput("mid_level", 32'(fifo_level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_satcnt", 32'(sat_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checkOutput($sformatf("post_rst_valid_%0d", k), 32'(m_valid), 32'd0);
    end
    checkOutput("post_rst_level", 32'(fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
